// File: rtl/cache_bus_arbiter_if.sv
// Refill bus bundle between the I/D cache refill requesters, the arbiter
// and the shared read-address/read-data channel.
// master : arbiter side (drives grants, AR channel, routed R beats)
// slave  : environment side (caches and memory)
interface cache_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // refill requests
  logic              ireq_valid;
  logic              dreq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic [ADDR_W-1:0] dreq_addr;
  logic [3:0]        ireq_len;
  logic [3:0]        dreq_len;
  logic              ireq_ready;
  logic              dreq_ready;
  // read address channel
  logic              ar_valid;
  logic [ADDR_W-1:0] ar_addr;
  logic [3:0]        ar_len;
  logic              ar_id;
  logic              ar_ready;
  // read data channel
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_ready;
  // routed beats
  logic              i_rvalid;
  logic              d_rvalid;
  logic              i_rlast;
  logic              d_rlast;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  ireq_valid, dreq_valid, ireq_addr, dreq_addr, ireq_len, dreq_len,
    output ireq_ready, dreq_ready,
    output ar_valid, ar_addr, ar_len, ar_id,
    input  ar_ready,
    input  r_valid, r_data, r_last,
    output r_ready,
    output i_rvalid, d_rvalid, i_rlast, d_rlast, rdata
  );

  modport slave (
    output ireq_valid, dreq_valid, ireq_addr, dreq_addr, ireq_len, dreq_len,
    input  ireq_ready, dreq_ready,
    input  ar_valid, ar_addr, ar_len, ar_id,
    output ar_ready,
    output r_valid, r_data, r_last,
    input  r_ready,
    input  i_rvalid, d_rvalid, i_rlast, d_rlast, rdata
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Two-master refill arbiter: ICache and DCache share one read bus.
// One transaction in flight at a time: IDLE -> AR -> R -> IDLE.
// Policy macro ARB_ROUND_ROBIN_EN: defined -> alternate on contention,
// undefined -> DCache has fixed priority.
module cache_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 resetn,
  cache_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2} state_t;

  state_t            state;
  logic              owner;      // 0 = ICache, 1 = DCache
  logic              req_any;
  logic              pick_d;
  logic [ADDR_W-1:0] grant_addr;
  logic [3:0]        grant_len;
  logic              beat;
  logic [DATA_W-1:0] beat_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_win;                // winner of the previous grant
`endif

  // Grant selection; only meaningful while IDLE.
  always_comb begin
    req_any = bus.ireq_valid | bus.dreq_valid;
`ifdef ARB_ROUND_ROBIN_EN
    // on contention the side that did not win last time goes first
    pick_d = bus.dreq_valid & (~bus.ireq_valid | ~last_win);
`else
    pick_d = bus.dreq_valid;
`endif
    grant_addr = pick_d ? bus.dreq_addr : bus.ireq_addr;
    grant_len  = pick_d ? bus.dreq_len  : bus.ireq_len;
  end

  // Transaction FSM with registered AR channel and r_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      owner        <= 1'b0;
      bus.ar_valid <= 1'b0;
      bus.ar_addr  <= '0;
      bus.ar_len   <= '0;
      bus.ar_id    <= 1'b0;
      bus.r_ready  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_win     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            owner        <= pick_d;
            bus.ar_id    <= pick_d;
            bus.ar_addr  <= grant_addr;
            bus.ar_len   <= grant_len;
            bus.ar_valid <= 1'b1;
            state        <= AR;
`ifdef ARB_ROUND_ROBIN_EN
            last_win     <= pick_d;
`endif
          end
        end
        AR: begin
          // address/len/id stay frozen until the slave accepts
          if (bus.ar_ready) begin
            bus.ar_valid <= 1'b0;
            bus.r_ready  <= 1'b1;
            state        <= R;
          end
        end
        R: begin
          if (bus.r_valid && bus.r_last) begin
            bus.r_ready <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          bus.ar_valid <= 1'b0;
          bus.r_ready  <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Accept pulse and beat routing are combinational off the registered
  // state, so reset silences them in the same cycle.
  always_comb begin
    beat      = (state == R) & bus.r_valid;
    beat_data = beat ? bus.r_data : '0;
  end

  assign bus.ireq_ready = (state == AR) & bus.ar_ready & ~owner;
  assign bus.dreq_ready = (state == AR) & bus.ar_ready &  owner;
  assign bus.i_rvalid   = beat & ~owner;
  assign bus.d_rvalid   = beat &  owner;
  assign bus.i_rlast    = beat & ~owner & bus.r_last;
  assign bus.d_rlast    = beat &  owner & bus.r_last;
  assign bus.rdata      = beat_data;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: expected AR grants are queued
// as stimulus is set up and popped by a monitor at each AR handshake.
module tb_cache_bus_arbiter;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  cache_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_exp_t;

  ar_exp_t exp_q[$];

  // AR handshake monitor: compare against scoreboard, check ready pulses.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.ar_valid && bus.ar_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected: id=%0d addr=%h, nothing expected", bus.ar_id, bus.ar_addr);
        end else begin
          ar_exp_t e;
          e = exp_q.pop_front();
          checks++;
          if ({bus.ar_id, bus.ar_addr, bus.ar_len} !== {e.id, e.addr, e.len}) begin
            errors++;
            $display("FAIL ar_grant: got id=%0d addr=%h len=%0d, want id=%0d addr=%h len=%0d",
                     bus.ar_id, bus.ar_addr, bus.ar_len, e.id, e.addr, e.len);
          end
          checks++;
          if ({bus.ireq_ready, bus.dreq_ready} !== {~e.id, e.id}) begin
            errors++;
            $display("FAIL req_ready_pulse: got i=%b d=%b, want i=%b d=%b",
                     bus.ireq_ready, bus.dreq_ready, ~e.id, e.id);
          end
        end
      end else begin
        checks++;
        if (bus.ireq_ready !== 1'b0 || bus.dreq_ready !== 1'b0) begin
          errors++;
          $display("FAIL stray_ready: i=%b d=%b without handshake, want 0 0",
                   bus.ireq_ready, bus.dreq_ready);
        end
      end
    end
  end

  function automatic logic all_outputs_zero();
    return ({bus.ireq_ready, bus.dreq_ready, bus.ar_valid, bus.ar_addr, bus.ar_len,
             bus.ar_id, bus.r_ready, bus.i_rvalid, bus.d_rvalid, bus.i_rlast,
             bus.d_rlast, bus.rdata} === '0);
  endfunction

  task automatic push_exp(input logic id, input logic [31:0] addr, input logic [3:0] len);
    ar_exp_t e;
    e.id = id; e.addr = addr; e.len = len;
    exp_q.push_back(e);
  endtask

  // Runs one transaction: waits for ar_valid, stalls ar_ready for ar_wait
  // extra cycles, then streams len+1 beats. rst_beat >= 0 asserts reset
  // in the middle of that beat and returns. wait_n = negedges spent before
  // ar_valid was seen.
  task automatic do_xfer(input logic id, input logic [3:0] len, input int ar_wait,
                         input bit drop, input int rst_beat, output int wait_n);
    logic [31:0] a0;
    logic [31:0] d;
    logic        exp_last;
    wait_n = 0;
    @(negedge clk);
    while (bus.ar_valid !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (wait_n >= 20) begin
      errors++;
      $display("FAIL ar_valid_timeout: no ar_valid within 20 cycles, want id=%0d", id);
      return;
    end
    checks++;
    if (bus.ar_id !== id || bus.r_ready !== 1'b0) begin
      errors++;
      $display("FAIL ar_owner: got id=%0d r_ready=%b, want id=%0d r_ready=0", bus.ar_id, bus.r_ready, id);
    end
    a0 = bus.ar_addr;
    @(posedge clk); #1;
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ar_valid !== 1'b1 || bus.ar_addr !== a0 || bus.ar_id !== id) begin
        errors++;
        $display("FAIL ar_stable: cycle %0d got valid=%b addr=%h id=%0d, want 1 %h %0d",
                 i, bus.ar_valid, bus.ar_addr, bus.ar_id, a0, id);
      end
      @(posedge clk); #1;
    end
    bus.ar_ready = 1'b1;
    @(posedge clk); #1;
    bus.ar_ready = 1'b0;
    if (drop) begin
      if (id) bus.dreq_valid = 1'b0;
      else    bus.ireq_valid = 1'b0;
    end
    for (int b = 0; b <= int'(len); b++) begin
      d = $urandom;
      exp_last = (b == int'(len));
      bus.r_valid = 1'b1;
      bus.r_data  = d;
      bus.r_last  = exp_last;
      if (b == rst_beat) begin
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (!all_outputs_zero()) begin
          errors++;
          $display("FAIL reset_mid_r: ar_valid=%b r_ready=%b i_rvalid=%b d_rvalid=%b rdata=%h, want all 0",
                   bus.ar_valid, bus.r_ready, bus.i_rvalid, bus.d_rvalid, bus.rdata);
        end
        return;
      end
      @(negedge clk);
      checks++;
      if (bus.r_ready !== 1'b1 || bus.i_rvalid !== ~id || bus.d_rvalid !== id ||
          bus.i_rlast !== (~id & exp_last) || bus.d_rlast !== (id & exp_last) || bus.rdata !== d) begin
        errors++;
        $display("FAIL beat_route: beat %0d got rr=%b iv=%b dv=%b il=%b dl=%b data=%h, want rr=1 iv=%b dv=%b il=%b dl=%b data=%h",
                 b, bus.r_ready, bus.i_rvalid, bus.d_rvalid, bus.i_rlast, bus.d_rlast, bus.rdata,
                 ~id, id, ~id & exp_last, id & exp_last, d);
      end
      @(posedge clk); #1;
    end
    bus.r_valid = 1'b0;
    bus.r_last  = 1'b0;
    // one bubble back in IDLE before any new grant is visible
    @(negedge clk);
    checks++;
    if (bus.ar_valid !== 1'b0 || bus.r_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_bubble: got ar_valid=%b r_ready=%b, want 0 0", bus.ar_valid, bus.r_ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.ireq_valid = 1'b1; bus.dreq_valid = 1'b0;
    bus.ireq_addr = 32'h1234_5600; bus.dreq_addr = '0;
    bus.ireq_len = 4'd2; bus.dreq_len = '0;
    bus.ar_ready = 1'b1; bus.r_valid = 1'b1; bus.r_data = 32'hDEAD_BEEF; bus.r_last = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (!all_outputs_zero()) begin
      errors++;
      $display("FAIL reset_state: ar_valid=%b r_ready=%b ireq_ready=%b i_rvalid=%b rdata=%h, want all 0",
               bus.ar_valid, bus.r_ready, bus.ireq_ready, bus.i_rvalid, bus.rdata);
    end
    bus.ireq_valid = 1'b0; bus.ar_ready = 1'b0;
    bus.r_valid = 1'b0; bus.r_last = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_single_i();
    int n;
    @(posedge clk); #1;
    bus.ireq_valid = 1'b1; bus.ireq_addr = 32'h1FC0_0000; bus.ireq_len = 4'd3;
    push_exp(1'b0, 32'h1FC0_0000, 4'd3);
    do_xfer(1'b0, 4'd3, 0, 1'b1, -1, n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL grant_latency: ar_valid after %0d cycles, want 1", n);
    end
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_policy();
    int n;
    @(posedge clk); #1;
    bus.ireq_valid = 1'b1; bus.ireq_addr = 32'h0000_1000; bus.ireq_len = 4'd0;
    bus.dreq_valid = 1'b1; bus.dreq_addr = 32'h0000_2000; bus.dreq_len = 4'd0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(1'b1, 32'h0000_2000, 4'd0);
      else            push_exp(1'b0, 32'h0000_1000, 4'd0);
    end
    for (int k = 0; k < 4; k++) begin
      do_xfer((k % 2 == 0), 4'd0, 0, 1'b0, -1, n);
    end
    bus.ireq_valid = 1'b0; bus.dreq_valid = 1'b0;
  endtask
`else
  task automatic test_policy();
    int n;
    @(posedge clk); #1;
    bus.ireq_valid = 1'b1; bus.ireq_addr = 32'h0000_1000; bus.ireq_len = 4'd1;
    bus.dreq_valid = 1'b1; bus.dreq_addr = 32'h0000_2000; bus.dreq_len = 4'd2;
    push_exp(1'b1, 32'h0000_2000, 4'd2);
    push_exp(1'b0, 32'h0000_1000, 4'd1);
    do_xfer(1'b1, 4'd2, 0, 1'b1, -1, n);
    do_xfer(1'b0, 4'd1, 0, 1'b1, -1, n);
  endtask
`endif

  // ar_ready low for five cycles of AR; a DCache request arriving during
  // AR must not disturb the in-flight ICache address.
  task automatic test_ar_stall();
    int n;
    @(posedge clk); #1;
    bus.ireq_valid = 1'b1; bus.ireq_addr = 32'h8000_0040; bus.ireq_len = 4'd1;
    push_exp(1'b0, 32'h8000_0040, 4'd1);
    push_exp(1'b1, 32'h0000_3000, 4'd0);
    @(posedge clk); #1;
    bus.dreq_valid = 1'b1; bus.dreq_addr = 32'h0000_3000; bus.dreq_len = 4'd0;
    do_xfer(1'b0, 4'd1, 4, 1'b1, -1, n);
    do_xfer(1'b1, 4'd0, 0, 1'b1, -1, n);
  endtask

  task automatic test_stray_r();
    @(posedge clk); #1;
    bus.r_valid = 1'b1; bus.r_data = 32'hCAFE_F00D; bus.r_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.r_ready !== 1'b0 || bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.ar_valid !== 1'b0) begin
        errors++;
        $display("FAIL stray_r: got r_ready=%b i_rvalid=%b d_rvalid=%b ar_valid=%b, want 0 0 0 0",
                 bus.r_ready, bus.i_rvalid, bus.d_rvalid, bus.ar_valid);
      end
    end
    @(posedge clk); #1;
    bus.r_valid = 1'b0; bus.r_last = 1'b0;
  endtask

  task automatic test_reset_mid_r();
    int n;
    @(posedge clk); #1;
    bus.dreq_valid = 1'b1; bus.dreq_addr = 32'h0000_4400; bus.dreq_len = 4'd3;
    push_exp(1'b1, 32'h0000_4400, 4'd3);
    // requester keeps dreq pending through the reset
    do_xfer(1'b1, 4'd3, 0, 1'b0, 1, n);
    bus.r_valid = 1'b0; bus.r_last = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    push_exp(1'b1, 32'h0000_4400, 4'd3);
    do_xfer(1'b1, 4'd3, 0, 1'b1, -1, n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL regrant_after_reset: ar_valid after %0d cycles, want 1", n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_policy();
    test_single_i();
    test_ar_stall();
    test_stray_r();
    test_reset_mid_r();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d grants never seen, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
